// File: rtl/flash_rom_loader.sv
// Copies a byte range from SPI flash into ROM memory.
// Fetches aligned 32-bit words from flash and writes them out one byte at a time.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for start; outputs quiet
//  S_FETCH  | flash_valid high at flash_addr until flash_ready
//  S_WRITE  | wr_req high with buffered byte[idx] until wr_ack
//  S_FINISH | done pulse (held one extra busy cycle for a zero-length load)
module flash_rom_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h200000,
    parameter int          LEN_W      = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             flash_valid,
    input  logic             flash_ready,
    output logic [23:0]      flash_addr,
    input  logic [31:0]      flash_rdata,
    output logic             wr_req,
    input  logic             wr_ack,
    output logic [23:0]      wr_addr,
    output logic [7:0]       wr_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] byte_cnt;
    logic [1:0]       idx;
    logic [31:0]      word_buf;
    logic             zero_hold;
    logic             take_cmd;
    logic             take_word;
    logic             take_ack;
    logic             last_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        flash_valid = 1'b0;
        wr_req      = 1'b0;
        take_cmd    = 1'b0;
        take_word   = 1'b0;
        take_ack    = 1'b0;
        last_byte   = (remaining == LEN_W'(1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    take_cmd  = 1'b1;
                    state_nxt = (length == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                busy        = 1'b1;
                flash_valid = 1'b1;
                if (flash_ready) begin
                    take_word = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy   = 1'b1;
                wr_req = 1'b1;
                if (wr_ack) begin
                    take_ack = 1'b1;
                    if (last_byte) begin
                        state_nxt = S_FINISH;
                    end else if (idx == 2'd3) begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FINISH: begin
                // A zero-length load still reports busy for one cycle before done.
                if (zero_hold) begin
                    busy = 1'b1;
                end else begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining  <= '0;
            byte_cnt   <= '0;
            idx        <= 2'd0;
            word_buf   <= 32'd0;
            flash_addr <= FLASH_BASE;
            zero_hold  <= 1'b0;
        end else begin
            if (take_cmd) begin
                remaining  <= length;
                byte_cnt   <= '0;
                flash_addr <= FLASH_BASE;
                zero_hold  <= (length == '0);
            end
            if (state == S_FINISH) begin
                zero_hold <= 1'b0;
            end
            if (take_word) begin
                word_buf <= flash_rdata;
                idx      <= 2'd0;
            end
            if (take_ack) begin
                remaining <= remaining - LEN_W'(1);
                byte_cnt  <= byte_cnt + LEN_W'(1);
                idx       <= idx + 2'd1;
                if (!last_byte && idx == 2'd3) begin
                    flash_addr <= flash_addr + 24'd4;
                end
            end
        end
    end

    assign wr_addr = 24'(byte_cnt);

    always_comb begin
        wr_data = word_buf[7:0];
        case (idx)
            2'd0: wr_data = word_buf[7:0];
            2'd1: wr_data = word_buf[15:8];
            2'd2: wr_data = word_buf[23:16];
            2'd3: wr_data = word_buf[31:24];
            default: wr_data = word_buf[7:0];
        endcase
    end

endmodule

// File: doc/flash_rom_loader.md
Name: flash_rom_loader

Overview:
Downstream consumer of the SPI flash word reader (valid/ready, 24-bit byte address, 32-bit little-endian read data). On a start command it copies a byte range from SPI flash into cartridge ROM memory: it requests aligned 32-bit words, splits each into bytes, and issues one handshaked byte write per byte. It sits between the flash reader and the SDRAM/BRAM ROM write port and is used at boot to load the SNES cartridge image.

Parameters:
FLASH_BASE, 24'h200000, flash byte offset of the ROM image; must be 4-byte aligned
LEN_W, 24, width of the byte-count input

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle load command; sampled only in IDLE
length  in  LEN_W  number of bytes to copy; sampled with start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the load completes
flash_valid  out  1  word request to the flash reader
flash_ready  in  1  one-cycle pulse: flash_rdata valid
flash_addr  out  24  flash byte address; always 4-byte aligned
flash_rdata  in  32  word; [7:0] is the byte at flash_addr
wr_req  out  1  byte write request to ROM memory
wr_ack  in  1  one-cycle write acknowledge
wr_addr  out  24  ROM byte address, 0-based
wr_data  out  8  ROM byte

Behaviour:
- Reset values: busy=0, done=0, flash_valid=0, flash_addr=FLASH_BASE, wr_req=0, wr_addr=0, wr_data=0. State = IDLE. Internal counters are cleared.
- Reset mid-operation: on the next edge all outputs return to their reset values. The in-flight flash word and write are abandoned, with no done pulse.
- States: IDLE, FETCH, WRITE, FINISH.
- IDLE: on start=1:
  - length==0: go to FINISH.
  - Otherwise latch remaining=length, set wr_addr=0 and flash_addr=FLASH_BASE, and go to FETCH.
  - Set busy=1 on the same edge in both cases.
- FETCH:
  - flash_valid=1, with flash_addr held stable throughout.
  - On the cycle flash_ready=1: latch flash_rdata into a word buffer, set byte index=0, and deassert flash_valid on that same edge. It must be low in the following cycle; the reader needs valid dropped after ready.
  - Go to WRITE.
- WRITE:
  - wr_req=1, with wr_data = buffer byte[index] (index 0 → bits 7:0, … index 3 → bits 31:24). wr_addr and wr_data are stable while wr_req=1.
  - On wr_ack=1: decrement remaining and increment wr_addr. Then:
    - remaining was 1: drop wr_req and go to FINISH.
    - else index was 3: drop wr_req, set flash_addr += 4, and go to FETCH.
    - else: index++ and present the next byte on the following cycle with wr_req still high (back-to-back allowed).
  - wr_ack while wr_req=0 is ignored.
- FINISH: one cycle with done=1 and busy=0 (busy falls on the same edge done rises), then IDLE.
- Partial last word: only `remaining` bytes of the final word are written; the upper bytes are discarded.
- start while busy is ignored. start and reset together: reset wins.
- Width rules:
  - flash_addr wraps modulo 2^24.
  - wr_addr is the byte count, LEN_W bits, zero-extended to 24.
  - length up to 2^LEN_W−1 is supported.
- Latency:
  - start at edge T → flash_valid high from T+1.
  - Each word costs 1 fetch handshake + 4 write handshakes, with no idle cycles beyond the handshakes themselves.
  - The final wr_ack at edge A → done high in cycle A+1.

Test Plan:
- Reset, then start with length=4; flash model returns 32'h44332211 at 24'h200000 → writes (0,11),(1,22),(2,33),(3,44) in order; exactly one flash request; one done pulse; busy low afterwards.
- length=6, words 32'hDDCCBBAA and 32'h00FF_EE11 → flash_addr 200000 then 200004; writes AA,BB,CC,DD,11,EE at addresses 0–5; bytes FF and 00 are never written.
- length=0 → done pulses 2 cycles after start; flash_valid and wr_req never assert.
- wr_ack delayed by a random 0–7 cycles and flash_ready by 60–70 cycles → wr_addr/wr_data/flash_addr stable while their request is high; flash_valid is low the cycle after each flash_ready.
- Second start pulse mid-load → ignored; the byte count and done timing match the first command only.
- Reset asserted while in WRITE with wr_req=1 → next cycle all outputs are at reset values and no done pulses; a following start with length=4 completes normally from address 0.
